// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-read-port register file: clear/ready handshake, write port, read lanes.
// The pending-write scoreboard signals exist only when REGFILE_SCOREBOARD_EN is defined.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2
);
   logic                    clr;
   logic                    ready;
   logic                    we;
   logic [ADDR_W-1:0]       wa;
   logic [DATA_W-1:0]       wn;
   logic [NREAD-1:0]        re;
   logic [NREAD*ADDR_W-1:0] ra;
   logic [NREAD*DATA_W-1:0] rn;
`ifdef REGFILE_SCOREBOARD_EN
   logic                    alloc;
   logic [ADDR_W-1:0]       alloc_a;
   logic [NREAD-1:0]        rv;

   modport master (
      output clr, we, wa, wn, re, ra, alloc, alloc_a,
      input  ready, rn, rv
   );

   modport slave (
      input  clr, we, wa, wn, re, ra, alloc, alloc_a,
      output ready, rn, rv
   );
`else
   modport master (
      output clr, we, wa, wn, re, ra,
      input  ready, rn
   );

   modport slave (
      input  clr, we, wa, wn, re, ra,
      output ready, rn
   );
`endif
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file: registered reads, write bypass, hardware clear sweep.
// Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard (alloc/alloc_a/rv).
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      SWEEP,
      RUN
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [ADDR_W-1:0]       ptr;
   logic [ADDR_W-1:0]       ptr_nx;
   logic [DATA_W-1:0]       mem [DEPTH];
   logic [NREAD*DATA_W-1:0] rn_q;
   logic [NREAD*DATA_W-1:0] rn_nx;
   logic [ADDR_W-1:0]       rdaddr [NREAD];
   logic [NREAD-1:0]        byp;
   logic                    wr_do;

   // A write lands only in RUN, loses to clr, and never touches a hardwired entry 0.
   assign wr_do = (state == RUN) && bus.we && !bus.clr &&
                  !((ZERO_REG != 0) && (bus.wa == '0));

   assign bus.ready = (state == RUN);
   assign bus.rn    = rn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SWEEP;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      case (state)
         SWEEP: begin
            if (bus.clr) begin
               ptr_nx = '0;
            end else if (&ptr) begin
               state_nx = RUN;
               ptr_nx   = '0;
            end else begin
               ptr_nx = ptr + 1'b1;
            end
         end
         RUN: begin
            if (bus.clr) begin
               state_nx = SWEEP;
               ptr_nx   = '0;
            end
         end
         default: begin
            state_nx = SWEEP;
            ptr_nx   = '0;
         end
      endcase
   end

   // Storage has no reset; the sweep is what guarantees every entry starts at zero.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         mem[ptr] <= '0;
      end else if (wr_do) begin
         mem[bus.wa] <= bus.wn;
      end
   end

   always_comb begin
      rn_nx = '0;
      byp   = '0;
      for (int k = 0; k < NREAD; k++) begin
         rdaddr[k] = bus.ra[k*ADDR_W +: ADDR_W];
         byp[k]    = wr_do && (bus.wa == rdaddr[k]);
         if ((state == RUN) && bus.re[k] &&
             !((ZERO_REG != 0) && (rdaddr[k] == '0))) begin
            if (byp[k]) begin
               rn_nx[k*DATA_W +: DATA_W] = bus.wn;
            end else begin
               rn_nx[k*DATA_W +: DATA_W] = mem[rdaddr[k]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rn_q <= '0;
      end else begin
         rn_q <= rn_nx;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] pending;
   logic [NREAD-1:0] rv_q;
   logic [NREAD-1:0] rv_nx;
   logic             alloc_ok;

   assign alloc_ok = bus.alloc && !((ZERO_REG != 0) && (bus.alloc_a == '0));
   assign bus.rv   = rv_q;

   // The set is issued after the clear so a same-address alloc and write leaves the entry pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (state == SWEEP) begin
         pending <= '0;
      end else begin
         if (wr_do) begin
            pending[bus.wa] <= 1'b0;
         end
         if (alloc_ok) begin
            pending[bus.alloc_a] <= 1'b1;
         end
      end
   end

   always_comb begin
      rv_nx = '0;
      for (int k = 0; k < NREAD; k++) begin
         rv_nx[k] = (state == RUN) && bus.re[k] && (!pending[rdaddr[k]] || byp[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv_q <= '0;
      end else begin
         rv_q <= rv_nx;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, read/write/bypass, zero register, clr and async reset.
// Expected read lanes are queued as each step is driven and popped once the registered output appears.
module tb_regfile_mp;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREAD  = 2;
   localparam int DEPTH  = 32;

   typedef struct {
      string             tag;
      logic [DATA_W-1:0] rn0;
      logic [DATA_W-1:0] rn1;
      logic [NREAD-1:0]  rv;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

   regfile_mp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NREAD(NREAD),
      .ZERO_REG(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkValue({e.tag, "_rn0"}, 64'(bus.rn[DATA_W-1:0]), 64'(e.rn0));
         checkValue({e.tag, "_rn1"}, 64'(bus.rn[2*DATA_W-1:DATA_W]), 64'(e.rn1));
`ifdef REGFILE_SCOREBOARD_EN
         checkValue({e.tag, "_rv"}, 64'(bus.rv), 64'(e.rv));
`endif
      end
   endtask

   // One clocked step: drive inputs, queue what the lanes must show after the edge, then check.
   task automatic applyStimulus(
      input string             tag,
      input logic              clr,
      input logic              we,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wn,
      input logic [NREAD-1:0]  re,
      input logic [ADDR_W-1:0] ra0,
      input logic [ADDR_W-1:0] ra1,
      input logic              alloc,
      input logic [ADDR_W-1:0] alloc_a,
      input logic [DATA_W-1:0] e0,
      input logic [DATA_W-1:0] e1,
      input logic [NREAD-1:0]  erv
   );
      exp_t e;
      bus.clr = clr;
      bus.we  = we;
      bus.wa  = wa;
      bus.wn  = wn;
      bus.re  = re;
      bus.ra  = {ra1, ra0};
`ifdef REGFILE_SCOREBOARD_EN
      bus.alloc   = alloc;
      bus.alloc_a = alloc_a;
`endif
      e.tag = tag;
      e.rn0 = e0;
      e.rn1 = e1;
      e.rv  = (alloc && (alloc_a == '1)) ? erv : erv;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      bus.we  = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
      bus.alloc = 1'b0;
`endif
      checkOutput();
   endtask

   // Counts edges until ready rises; lanes must stay zero throughout the sweep.
   task automatic waitReady(input string tag, input int expEdges);
      int n;
      n       = 0;
      bus.clr = 1'b0;
      bus.we  = 1'b0;
      bus.re  = 2'b11;
      bus.ra  = {5'd31, 5'd3};
      while ((bus.ready !== 1'b1) && (n < 200)) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.ready !== 1'b1) begin
            checkValue({tag, "_sweep_rn"}, bus.rn, 64'd0);
`ifdef REGFILE_SCOREBOARD_EN
            checkValue({tag, "_sweep_rv"}, 64'(bus.rv), 64'd0);
`endif
         end
      end
      checkValue({tag, "_edges"}, 64'(n), 64'(expEdges));
   endtask

   initial begin
      bus.clr = 1'b0;
      bus.we  = 1'b0;
      bus.wa  = '0;
      bus.wn  = '0;
      bus.re  = '0;
      bus.ra  = '0;
`ifdef REGFILE_SCOREBOARD_EN
      bus.alloc   = 1'b0;
      bus.alloc_a = '0;
`endif

      repeat (2) @(posedge clk);
      #1;
      checkValue("reset_ready", 64'(bus.ready), 64'd0);
      checkValue("reset_rn", bus.rn, 64'd0);
      rst_n = 1'b1;
      waitReady("rst_release", DEPTH);

      applyStimulus("read_after_sweep", 0, 0, 0, 0, 2'b11, 5'd3, 5'd31, 0, 0, 32'h0, 32'h0, 2'b11);
      applyStimulus("write5", 0, 1, 5'd5, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      applyStimulus("read5", 0, 0, 0, 0, 2'b01, 5'd5, 5'd0, 0, 0, 32'hDEADBEEF, 32'h0, 2'b01);
      applyStimulus("write7", 0, 1, 5'd7, 32'h11, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      applyStimulus("bypass7", 0, 1, 5'd7, 32'h22, 2'b11, 5'd7, 5'd7, 0, 0, 32'h22, 32'h22, 2'b11);
      applyStimulus("nobypass7", 0, 0, 5'd7, 32'h33, 2'b11, 5'd7, 5'd7, 0, 0, 32'h22, 32'h22, 2'b11);
      applyStimulus("zero_write", 0, 1, 5'd0, 32'hFFFFFFFF, 2'b01, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 2'b01);
      applyStimulus("zero_read", 0, 0, 0, 0, 2'b11, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 2'b11);
      applyStimulus("mixed_lanes", 0, 1, 5'd8, 32'h44, 2'b11, 5'd8, 5'd5, 0, 0, 32'h44, 32'hDEADBEEF, 2'b11);
      applyStimulus("lane0_off", 0, 0, 0, 0, 2'b10, 5'd8, 5'd8, 0, 0, 32'h0, 32'h44, 2'b10);

      #1 rst_n = 1'b0;
      #1;
      checkValue("async_rst_ready", 64'(bus.ready), 64'd0);
      checkValue("async_rst_rn", bus.rn, 64'd0);
      #1 rst_n = 1'b1;
      waitReady("rst_run", DEPTH);
      applyStimulus("swept_5_8", 0, 0, 0, 0, 2'b11, 5'd5, 5'd8, 0, 0, 32'h0, 32'h0, 2'b11);

      applyStimulus("write3", 0, 1, 5'd3, 32'h77, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      applyStimulus("clr_drops_write", 1, 1, 5'd3, 32'hABCD, 2'b01, 5'd3, 5'd0, 0, 0, 32'h77, 32'h0, 2'b01);
      checkValue("clr_ready_low", 64'(bus.ready), 64'd0);
      waitReady("clr_run", DEPTH);
      applyStimulus("read3_after_clr", 0, 0, 0, 0, 2'b01, 5'd3, 5'd0, 0, 0, 32'h0, 32'h0, 2'b01);

      applyStimulus("clr_again", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      repeat (5) @(posedge clk);
      #1 bus.clr = 1'b1;
      @(posedge clk);
      #1 bus.clr = 1'b0;
      waitReady("clr_sweep", DEPTH);

      applyStimulus("clr_for_rst", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkValue("sweep_rst_ready", 64'(bus.ready), 64'd0);
      checkValue("sweep_rst_rn", bus.rn, 64'd0);
      #1 rst_n = 1'b1;
      waitReady("rst_sweep", DEPTH);

`ifdef REGFILE_SCOREBOARD_EN
      applyStimulus("alloc9", 0, 0, 0, 0, 2'b00, 0, 0, 1, 5'd9, 32'h0, 32'h0, 2'b00);
      applyStimulus("read9_pending", 0, 0, 0, 0, 2'b11, 5'd9, 5'd4, 0, 0, 32'h0, 32'h0, 2'b10);
      applyStimulus("write9_bypass", 0, 1, 5'd9, 32'h5, 2'b01, 5'd9, 5'd0, 0, 0, 32'h5, 32'h0, 2'b01);
      applyStimulus("read9_done", 0, 0, 0, 0, 2'b11, 5'd9, 5'd9, 0, 0, 32'h5, 32'h5, 2'b11);
      applyStimulus("alloc_write12", 0, 1, 5'd12, 32'h6, 2'b00, 0, 0, 1, 5'd12, 32'h0, 32'h0, 2'b00);
      applyStimulus("read12_pending", 0, 0, 0, 0, 2'b01, 5'd12, 5'd0, 0, 0, 32'h6, 32'h0, 2'b00);
      applyStimulus("alloc0", 0, 0, 0, 0, 2'b00, 0, 0, 1, 5'd0, 32'h0, 32'h0, 2'b00);
      applyStimulus("read0_valid", 0, 0, 0, 0, 2'b01, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 2'b01);
      applyStimulus("clr_pending", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
      waitReady("clr_sb", DEPTH);
      applyStimulus("read12_cleared", 0, 0, 0, 0, 2'b01, 5'd12, 5'd0, 0, 0, 32'h0, 32'h0, 2'b01);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the CPU decode/register-read stage. It generalises the two-port file to a configurable data width, depth and read-port count. Reads are registered with write-to-read bypass gated on a real write. After reset or a flush request, a hardware clear-sweep state machine zeroes every entry, so the storage array itself needs no reset.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NREAD, 2, number of independent read ports
ZERO_REG, 1, 1 = entry 0 is hardwired to zero (writes dropped, reads return 0); 0 = entry 0 is ordinary storage

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
clr  in  1  synchronous request to re-run the clear sweep
ready  out  1  1 = sweep finished, file accepts reads/writes
we  in  1  write enable
wa  in  ADDR_W  write address
wn  in  DATA_W  write data
re  in  NREAD  per-port read enable; bit k belongs to port k
ra  in  NREAD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rn  out  NREAD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset is asynchronous, active-low: rst_n=0 immediately forces state=SWEEP, sweep pointer ptr=0, ready=0 and every rn lane=0. The storage array is not reset.
- FSM states: SWEEP and RUN.
- SWEEP: each rising edge writes mem[ptr] <= 0 and increments ptr.
  - When ptr==DEPTH-1, the next state is RUN.
  - ready goes 1 on the edge that leaves SWEEP, i.e. exactly DEPTH edges after rst_n rises.
- In SWEEP: we is ignored, every rn lane is driven to 0 on each edge, and re is ignored.
- clr=1 in RUN: next edge enters SWEEP with ptr=0 and ready=0. A write in the same cycle is dropped (clr wins).
- clr=1 in SWEEP: ptr restarts at 0 on the next edge.
- Write, RUN only: on the edge, if we=1, mem[wa] <= wn, unless ZERO_REG=1 and wa==0.
- Read, RUN only, per port k, 1-cycle latency. On each edge:
  - re[k]=0: rn_k <= 0.
  - ZERO_REG=1 and ra_k==0: rn_k <= 0.
  - we=1, wa==ra_k, and the write is not dropped: rn_k <= wn (bypass).
  - Otherwise: rn_k <= mem[ra_k] (old contents).
- The bypass requires we=1. An address match with we=0 returns stored data.
- Multiple ports may read the same address in the same cycle; each lane returns the identical value.
- Reset mid-sweep or mid-operation behaves exactly like any reset: the sweep restarts from entry 0 after rst_n rises.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined: adds ports
  - alloc  in  1
  - alloc_a  in  ADDR_W
  - rv  out  NREAD, per-port "data valid"
- Scoreboard: a DEPTH-bit pending vector, cleared to 0 by reset and by every sweep.
- In RUN, each edge:
  - alloc=1 sets pending[alloc_a] (never for entry 0 when ZERO_REG=1).
  - A performed write clears pending[wa].
  - If alloc and the write target the same address in the same cycle, the set wins.
- rv_k is registered alongside rn_k:
  - rv_k = 1 when re[k]=1 and either pending[ra_k]=0 or the read is bypassed this cycle.
  - rv_k = 0 in SWEEP and at reset.
- Not defined: none of these ports or logic exist; the interface is exactly as listed above.

Test Plan:
- Reset release, DEPTH=32: rst_n 0->1 -> ready=0 for 32 edges, then 1; reading any address with re=11 returns rn=0 on both lanes.
- Write then read: we=1, wa=5, wn=0xDEADBEEF; next cycle re[0]=1, ra0=5 -> rn0=0xDEADBEEF one edge later.
- Bypass: mem[7]=0x11; same cycle we=1, wa=7, wn=0x22 and ra0=ra1=7 -> both lanes 0x22. Repeat with we=0, wa=7 -> both lanes 0x22 (stored value, not wn).
- Zero register: we=1, wa=0, wn=0xFFFFFFFF with ra0=0 -> rn0=0 that cycle and on every later read of address 0.
- clr in RUN with a simultaneous write to 3 -> ready=0 for 32 edges; afterwards mem[3] reads 0. rst_n pulsed low at sweep entry 10 -> rn=0 and ready=0 immediately, and the sweep restarts (32 edges).
- With REGFILE_SCOREBOARD_EN: alloc addr 9, then read 9 -> rv0=0; write 9 with 0x5 while reading 9 -> rv0=1 and rn0=0x5.
